// File: rtl/clk_div_n.sv
// ---------------------------------------------------------------------------
// clk_div_n
//
// Runtime-programmable integer clock divider with a 50% duty cycle for both
// odd and even divisors. The divisor can be reloaded while running; a new
// value only takes effect on a period boundary (or at once while stopped),
// so t never shows a truncated or runt pulse.
//
// Ports:
//   clk       in   single clock; posedge is the main domain, negedge only
//                  feeds the odd-divisor retime flop
//   rst       in   synchronous, active-high reset
//   en        in   run enable
//   div_in    in   [WIDTH] requested divisor N (must be >= 2)
//   div_load  in   one-cycle request to load div_in
//   div_ack   out  one-cycle pulse in the first cycle of a period that uses
//                  a newly loaded divisor
//   div_err   out  one-cycle pulse after a rejected load (div_in < 2)
//   t         out  divided clock, period N*Tclk, high time N/2*Tclk
//   tick      out  one-cycle pulse in the first cycle of each output period
// ---------------------------------------------------------------------------
module clk_div_n #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic             t,
    output logic             tick
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_cur;
    logic [WIDTH-1:0] r_div_pend;
    logic             r_pend;
    logic             r_pos_q;
    logic             r_neg_q;
    logic             r_ack;
    logic             r_err;
    logic             r_tick;

    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_half;
    logic [WIDTH-1:0] w_div_cur_nxt;
    logic [WIDTH-1:0] w_div_pend_nxt;
    logic             w_pend_nxt;
    logic             w_pos_nxt;
    logic             w_ack_nxt;
    logic             w_err_nxt;
    logic             w_tick_nxt;
    logic             w_boundary;
    logic             w_load_ok;
    logic             w_apply;

    always_comb begin
        // High phase length H = ceil(N/2), formed without widening so that
        // N = 2^WIDTH-1 cannot carry out of WIDTH bits.
        w_half     = {1'b0, r_div_cur[WIDTH-1:1]} + {{(WIDTH-1){1'b0}}, r_div_cur[0]};
        w_cnt_inc  = r_cnt + WIDTH'(1);
        w_boundary = (r_state == ST_RUN) && (r_cnt == (r_div_cur - WIDTH'(1)));
        w_load_ok  = div_load && (div_in >= WIDTH'(2));
        // Only a load registered before this cycle may be applied, so a
        // request arriving in the boundary cycle waits for the next boundary.
        w_apply    = r_pend && (w_boundary || (r_state == ST_STOP));

        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_pos_nxt      = r_pos_q;
        w_tick_nxt     = 1'b0;
        w_ack_nxt      = w_apply;
        w_err_nxt      = div_load && !w_load_ok;
        w_div_cur_nxt  = w_apply ? r_div_pend : r_div_cur;
        w_div_pend_nxt = r_div_pend;
        w_pend_nxt     = r_pend;

        // A fresh valid request wins over clearing the flag for the one just
        // applied: last request wins, and it stays pending.
        if (w_load_ok) begin
            w_div_pend_nxt = div_in;
            w_pend_nxt     = 1'b1;
        end else if (w_apply) begin
            w_pend_nxt = 1'b0;
        end

        case (r_state)
            ST_RUN: begin
                if (w_boundary) begin
                    w_cnt_nxt = '0;
                    if (en) begin
                        w_pos_nxt  = 1'b1;
                        w_tick_nxt = 1'b1;
                    end else begin
                        // Park low at cnt=0 once the current period is done.
                        w_state_nxt = ST_STOP;
                        w_pos_nxt   = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    w_pos_nxt = (w_cnt_inc < w_half);
                end
            end
            default: begin
                w_cnt_nxt = '0;
                w_pos_nxt = 1'b0;
                if (en) begin
                    w_state_nxt = ST_RUN;
                    w_pos_nxt   = 1'b1;
                    w_tick_nxt  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_STOP;
            r_cnt      <= '0;
            r_div_cur  <= DIV_RST;
            r_div_pend <= DIV_RST;
            r_pend     <= 1'b0;
            r_pos_q    <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_div_cur  <= w_div_cur_nxt;
            r_div_pend <= w_div_pend_nxt;
            r_pend     <= w_pend_nxt;
            r_pos_q    <= w_pos_nxt;
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
            r_tick     <= w_tick_nxt;
        end
    end

    // Half-cycle delayed copy of the phase; ANDing it with r_pos_q trims the
    // rising edge by half a clock, giving exact 50% duty for odd divisors.
    always_ff @(negedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
        end else begin
            r_neg_q <= r_pos_q;
        end
    end

    assign t       = r_div_cur[0] ? (r_pos_q & r_neg_q) : r_pos_q;
    assign tick    = r_tick;
    assign div_ack = r_ack;
    assign div_err = r_err;

endmodule
